// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: op codes, FSM states, flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADC  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_DIV  = 4'h9;
    localparam logic [3:0] OP_PASS = 4'hF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Flag bundle, ordered {CF,ZF,SF,OF}.
    typedef struct packed {
        logic cf;
        logic zf;
        logic sf;
        logic of;
    } flags_t;

    // Multiply and divide are the only ops that take the iterative path.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// start/busy/done handshake between the controller and the registered ALU.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res;
    logic             CF;
    logic             ZF;
    logic             SF;
    logic             OF;

    modport master (
        output start, op, in1, in2,
        input  busy, done, res, CF, ZF, SF, OF
    );

    modport slave (
        input  start, op, in1, in2,
        output busy, done, res, CF, ZF, SF, OF
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier and restoring divider. Both share one
// WIDTH+1 adder/subtractor; one iteration per clock while the counter is non-zero.
// lo_next/hi_next show the register contents after the current iteration, so the
// caller can capture the final result on the edge flagged by 'last'.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             div_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic             div_mode,
    output logic             div_zero,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi_next
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;      // product high half / partial remainder
    logic [WIDTH-1:0] mq;       // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] md;       // multiplicand / divisor
    logic             is_div;
    logic             dz;

    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_sub;
    logic [WIDTH+1:0] add_full;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mq_nxt;

    // Operand steering into the shared adder: divide subtracts the divisor from
    // the shifted remainder, multiply conditionally adds the multiplicand.
    always_comb begin
        if (is_div) begin
            add_a   = {acc, mq[WIDTH-1]};
            add_b   = {1'b0, md};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, acc};
            add_b   = mq[0] ? {1'b0, md} : '0;
            add_sub = 1'b0;
        end
    end

    // Extra top bit is the carry-out; for subtraction it means "no borrow".
    assign add_full = {1'b0, add_a}
                    + {1'b0, add_b ^ {(WIDTH+1){add_sub}}}
                    + {{(WIDTH+1){1'b0}}, add_sub};

    // Next-state of the shift registers for one iteration.
    always_comb begin
        if (is_div) begin
            if (add_full[WIDTH+1]) begin
                acc_nxt = add_full[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = add_a[WIDTH-1:0];
                mq_nxt  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = add_full[WIDTH:1];
            mq_nxt  = {add_full[0], mq[WIDTH-1:1]};
        end
    end

    assign last     = (count == CW'(1));
    assign lo_next  = mq_nxt;
    assign hi_next  = acc_nxt;
    assign div_mode = is_div;
    assign div_zero = dz;

    // Operand load and iteration counter; reset clears everything, aborting a run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            acc    <= '0;
            mq     <= '0;
            md     <= '0;
            is_div <= 1'b0;
            dz     <= 1'b0;
        end else if (load) begin
            count  <= CW'(WIDTH);
            acc    <= '0;
            mq     <= a;
            md     <= b;
            is_div <= div_sel;
            dz     <= div_sel && (b == '0);
        end else if (count != '0) begin
            count  <= count - CW'(1);
            acc    <= acc_nxt;
            mq     <= mq_nxt;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with held result/flags and a start/busy/done handshake.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; single-cycle ops complete on the accept edge
//   RUN   | MUL/DIV iterating, busy=1, result written on the final edge
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    alu_seq_if.slave   bus
);
    localparam int M = WIDTH - 1;

    state_t           state;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] res_q;
    flags_t           flags_q;

    logic [WIDTH-1:0] sc_res;
    flags_t           sc_flags;
    logic             sc_zs;
    logic [WIDTH:0]   sum;

    logic             accept;
    logic             md_load;
    logic             md_last;
    logic             md_div;
    logic             md_dz;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    flags_t           md_flags;

    assign accept  = (state == IDLE) && bus.start;
    assign md_load = accept && is_iter_op(bus.op);

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .div_sel  (bus.op == OP_DIV),
        .a        (bus.in1),
        .b        (bus.in2),
        .last     (md_last),
        .div_mode (md_div),
        .div_zero (md_dz),
        .lo_next  (md_lo),
        .hi_next  (md_hi)
    );

    // Single-cycle datapath; PASS and reserved codes leave flags as they are.
    always_comb begin
        sc_res   = res_q;
        sc_flags = flags_q;
        sc_zs    = 1'b1;
        sum      = '0;
        case (bus.op)
            OP_ADD, OP_ADC: begin
                sum = {1'b0, bus.in1} + {1'b0, bus.in2}
                    + {{WIDTH{1'b0}}, (bus.op == OP_ADC) & flags_q.cf};
                sc_res      = sum[M:0];
                sc_flags.cf = sum[WIDTH];
                sc_flags.of = (bus.in1[M] == bus.in2[M]) && (sum[M] != bus.in1[M]);
            end
            OP_SUB: begin
                sum = {1'b0, bus.in1} - {1'b0, bus.in2};
                sc_res      = sum[M:0];
                sc_flags.cf = sum[WIDTH];
                sc_flags.of = (bus.in1[M] != bus.in2[M]) && (sum[M] != bus.in1[M]);
            end
            OP_AND, OP_OR, OP_XOR: begin
                sc_res      = (bus.op == OP_AND) ? (bus.in1 & bus.in2) :
                              (bus.op == OP_OR)  ? (bus.in1 | bus.in2) :
                                                   (bus.in1 ^ bus.in2);
                sc_flags.cf = 1'b0;
                sc_flags.of = 1'b0;
            end
            OP_SHL: begin
                sc_res      = {bus.in1[M-1:0], 1'b0};
                sc_flags.cf = bus.in1[M];
                sc_flags.of = 1'b0;
            end
            OP_SHR: begin
                sc_res      = {1'b0, bus.in1[M:1]};
                sc_flags.cf = bus.in1[0];
                sc_flags.of = 1'b0;
            end
            OP_PASS: begin
                sc_res = bus.in1;
                sc_zs  = 1'b0;
            end
            default: sc_zs = 1'b0;
        endcase
        if (sc_zs) begin
            sc_flags.zf = (sc_res == '0);
            sc_flags.sf = sc_res[M];
        end
    end

    // Flags for the iterative result; divide-by-zero reports through OF.
    always_comb begin
        md_flags.cf = md_div ? 1'b0  : (md_hi != '0);
        md_flags.of = md_div ? md_dz : (md_hi != '0);
        md_flags.zf = (md_lo == '0);
        md_flags.sf = md_lo[M];
    end

    // Control FSM with registered busy/done and held result/flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_iter_op(bus.op)) begin
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else begin
                            res_q   <= sc_res;
                            flags_q <= sc_flags;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (md_last) begin
                        res_q   <= md_lo;
                        flags_q <= md_flags;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.res  = res_q;
    assign bus.CF   = flags_q.cf;
    assign bus.ZF   = flags_q.zf;
    assign bus.SF   = flags_q.sf;
    assign bus.OF   = flags_q.of;

endmodule
